// File: rtl/bb_bus_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// bb_bus_sequencer_pkg
// Shared definitions for the register-file micro-sequencer:
//   - enable bit indices on the 16-bit ien/oen unit buses
//   - opcode values (IR[7:4])
//   - FSM state encoding
//   - decoded-instruction record passed from bb_seq_decode to the top
//   - small helpers for one-hot enable masks and register-index checks
// -----------------------------------------------------------------------------
package bb_bus_sequencer_pkg;

  // Unit enable bit positions on o_unit_ien / o_unit_oen
  localparam logic [3:0] INDEX_EN_IR       = 4'd1;
  localparam logic [3:0] INDEX_EN_PC       = 4'd2;
  localparam logic [3:0] INDEX_EN_AR       = 4'd3;
  localparam logic [3:0] INDEX_EN_DR0      = 4'd4;
  localparam logic [3:0] INDEX_EN_DR1      = 4'd5;
  localparam logic [3:0] INDEX_EN_CR       = 4'd6;
  localparam logic [3:0] INDEX_EN_SKIN_INC = 4'd12;
  localparam logic [3:0] INDEX_EN_SKIN     = 4'd13;

  // Opcodes
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_ST   = 4'h2;
  localparam logic [3:0] OP_LDI  = 4'h3;
  localparam logic [3:0] OP_INC  = 4'h4;
  localparam logic [3:0] OP_BR   = 4'h5;
  localparam logic [3:0] OP_BZ   = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Sequencer states. LOAD is the single cycle that moves the fetched word
  // into IR, so DECODE always sees the freshly loaded instruction.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_DECODE  = 3'd3,
    ST_EXEC    = 3'd4,
    ST_MEMWAIT = 3'd5,
    ST_HALT    = 3'd6
  } state_t;

  // Decoded instruction. req_oen_mask is driven during the memory request
  // phase (store source); oen_mask/ien_mask are the single-cycle execute move.
  typedef struct packed {
    logic        mem_op;
    logic        we;
    logic        addr_sel;
    logic [15:0] req_oen_mask;
    logic [15:0] oen_mask;
    logic [15:0] ien_mask;
    logic        halt;
    logic        illegal;
  } dec_t;

  // One-hot enable mask for a bus index
  function automatic logic [15:0] en_bit(input logic [3:0] idx);
    en_bit = 16'h0001 << idx;
  endfunction

  // Only AR, DR0, DR1 and CR may be memory targets/sources
  function automatic logic idx_valid(input logic [3:0] idx);
    idx_valid = (idx >= INDEX_EN_AR) && (idx <= INDEX_EN_CR);
  endfunction

endpackage

// File: rtl/bb_seq_decode.sv
// -----------------------------------------------------------------------------
// bb_seq_decode
// Purely combinational instruction decoder for bb_bus_sequencer.
// Ports:
//   opcode  in   4   IR[7:4]
//   index   in   4   IR[3:0] register index
//   zero    in   1   condition flag used by BZ
//   dec     out  dec_t  memory-op flags, enable masks, halt, illegal
// -----------------------------------------------------------------------------
module bb_seq_decode
  import bb_bus_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] index,
  input  logic       zero,
  output dec_t       dec
);

  // Map opcode/index onto bus moves; anything unrecognised is illegal
  always_comb begin
    dec = '0;
    case (opcode)
      OP_NOP: begin
        dec.illegal = 1'b0;
      end
      OP_LD: begin
        if (idx_valid(index)) begin
          dec.mem_op   = 1'b1;
          dec.addr_sel = 1'b1;
          dec.oen_mask = en_bit(INDEX_EN_SKIN);
          dec.ien_mask = en_bit(index);
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_ST: begin
        if (idx_valid(index)) begin
          dec.mem_op       = 1'b1;
          dec.we           = 1'b1;
          dec.addr_sel     = 1'b1;
          dec.req_oen_mask = en_bit(index);
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_LDI: begin
        // Immediate follows the instruction; reading it via SKIN_INC
        // moves PC past it.
        if (idx_valid(index)) begin
          dec.mem_op   = 1'b1;
          dec.oen_mask = en_bit(INDEX_EN_SKIN_INC);
          dec.ien_mask = en_bit(index);
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_INC: begin
        dec.oen_mask = en_bit(INDEX_EN_DR0);
        dec.ien_mask = en_bit(INDEX_EN_DR0);
      end
      OP_BR: begin
        dec.oen_mask = en_bit(INDEX_EN_CR);
        dec.ien_mask = en_bit(INDEX_EN_PC);
      end
      OP_BZ: begin
        if (zero) begin
          dec.oen_mask = en_bit(INDEX_EN_CR);
          dec.ien_mask = en_bit(INDEX_EN_PC);
        end else begin
          dec.illegal = 1'b0;
        end
      end
      OP_HALT: begin
        dec.halt = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/bb_bus_sequencer.sv
// -----------------------------------------------------------------------------
// bb_bus_sequencer
// Fetch/decode/execute micro-sequencer driving the register-file unit enable
// buses and the skin-side memory req/ack port. Every output is a flop loaded
// from the next-state decode, so i_mem_ack never reaches an enable
// combinationally and each bus move lasts exactly one clock.
//
// Optional feature: define BB_SEQ_TIMEOUT_EN to enable the memory-ack
// watchdog (TIMEOUT_CYCLES). Without it the sequencer waits forever for ack
// and o_error is held at 0.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_start         leave IDLE/HALT and begin fetching
//   i_instruction   current IR contents (opcode IR[7:4], index IR[3:0])
//   i_zero          BZ condition flag
//   i_mem_ack       memory transfer complete (one-cycle pulse)
//   o_mem_req       memory request, held until ack
//   o_mem_we        store when high, valid with o_mem_req
//   o_addr_sel      memory address source: 0 = PC, 1 = AR
//   o_unit_ien      register load enables (one-hot or zero)
//   o_unit_oen      bus source enables (one-hot or zero)
//   o_busy          any state other than IDLE/HALT
//   o_halt          in HALT
//   o_illegal       one-cycle pulse on an undefined opcode or index
//   o_error         sticky watchdog error
// -----------------------------------------------------------------------------
module bb_bus_sequencer
  import bb_bus_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_instruction,
  input  logic                  i_zero,
  input  logic                  i_mem_ack,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic                  o_addr_sel,
  output logic [15:0]           o_unit_ien,
  output logic [15:0]           o_unit_oen,
  output logic                  o_busy,
  output logic                  o_halt,
  output logic                  o_illegal,
  output logic                  o_error
);

  state_t      state_r, state_nx_s;
  dec_t        dec_s, dec_r, dec_cur_s;
  logic        req_r, we_r, asel_r, busy_r, halt_r, illegal_r, error_r;
  logic [15:0] ien_r, oen_r;
  logic        req_nx_s, we_nx_s, asel_nx_s, illegal_nx_s, error_nx_s;
  logic [15:0] ien_nx_s, oen_nx_s;
  logic        timeout_s;

  bb_seq_decode u_decode (
    .opcode (i_instruction[7:4]),
    .index  (i_instruction[3:0]),
    .zero   (i_zero),
    .dec    (dec_s)
  );

  // The decode is captured in DECODE so later phases do not depend on IR
  assign dec_cur_s = (state_r == ST_DECODE) ? dec_s : dec_r;

`ifdef BB_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_RAW_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W     = (CNT_RAW_W < 8)  ? 8 :
                                      (CNT_RAW_W > 16) ? 16 : CNT_RAW_W;
  logic [CNT_W-1:0] cnt_r, cnt_inc_s;

  assign cnt_inc_s = cnt_r + CNT_W'(1);
  // Fires on the request cycle whose missing ack would make the count reach
  // the limit; ack wins if it arrives on that same cycle.
  assign timeout_s = ((state_r == ST_FETCH) || (state_r == ST_MEMWAIT)) &&
                     !i_mem_ack && (cnt_inc_s == CNT_W'(TIMEOUT_CYCLES));

  // Watchdog counter: cleared on entry to a request state, counts unacked cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if ((state_nx_s != state_r) &&
                 ((state_nx_s == ST_FETCH) || (state_nx_s == ST_MEMWAIT))) begin
      cnt_r <= '0;
    end else if (((state_r == ST_FETCH) || (state_r == ST_MEMWAIT)) && !i_mem_ack) begin
      cnt_r <= cnt_inc_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next state and next registered outputs
  always_comb begin
    state_nx_s   = state_r;
    error_nx_s   = error_r;
    req_nx_s     = 1'b0;
    we_nx_s      = 1'b0;
    asel_nx_s    = 1'b0;
    ien_nx_s     = 16'h0000;
    oen_nx_s     = 16'h0000;
    illegal_nx_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          state_nx_s = ST_FETCH;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (i_mem_ack) begin
          state_nx_s = ST_LOAD;
        end else if (timeout_s) begin
          state_nx_s = ST_HALT;
          error_nx_s = 1'b1;
        end else begin
          state_nx_s = ST_FETCH;
        end
      end
      ST_LOAD: begin
        state_nx_s = ST_DECODE;
      end
      ST_DECODE: begin
        if (dec_s.mem_op) begin
          state_nx_s = ST_MEMWAIT;
        end else if (dec_s.halt) begin
          state_nx_s = ST_HALT;
        end else begin
          state_nx_s = ST_EXEC;
        end
      end
      ST_MEMWAIT: begin
        if (i_mem_ack) begin
          state_nx_s = ST_EXEC;
        end else if (timeout_s) begin
          state_nx_s = ST_HALT;
          error_nx_s = 1'b1;
        end else begin
          state_nx_s = ST_MEMWAIT;
        end
      end
      ST_EXEC: begin
        state_nx_s = ST_FETCH;
      end
      ST_HALT: begin
        // A watchdog error parks the sequencer until rst
        if (i_start && !error_r) begin
          state_nx_s = ST_FETCH;
        end else begin
          state_nx_s = ST_HALT;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase

    case (state_nx_s)
      ST_FETCH: begin
        req_nx_s = 1'b1;
      end
      ST_LOAD: begin
        oen_nx_s = en_bit(INDEX_EN_SKIN_INC);
        ien_nx_s = en_bit(INDEX_EN_IR);
      end
      ST_MEMWAIT: begin
        req_nx_s  = 1'b1;
        we_nx_s   = dec_cur_s.we;
        asel_nx_s = dec_cur_s.addr_sel;
        oen_nx_s  = dec_cur_s.req_oen_mask;
      end
      ST_EXEC: begin
        // After a memory op this is the ack-follow-up cycle (store: all zero)
        oen_nx_s     = dec_cur_s.oen_mask;
        ien_nx_s     = dec_cur_s.ien_mask;
        illegal_nx_s = dec_cur_s.illegal;
      end
      default: begin
        req_nx_s = 1'b0;
      end
    endcase
  end

  // State, captured decode and all output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      dec_r     <= '0;
      req_r     <= 1'b0;
      we_r      <= 1'b0;
      asel_r    <= 1'b0;
      ien_r     <= 16'h0000;
      oen_r     <= 16'h0000;
      busy_r    <= 1'b0;
      halt_r    <= 1'b0;
      illegal_r <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      dec_r     <= (state_r == ST_DECODE) ? dec_s : dec_r;
      req_r     <= req_nx_s;
      we_r      <= we_nx_s;
      asel_r    <= asel_nx_s;
      ien_r     <= ien_nx_s;
      oen_r     <= oen_nx_s;
      busy_r    <= (state_nx_s != ST_IDLE) && (state_nx_s != ST_HALT);
      halt_r    <= (state_nx_s == ST_HALT);
      illegal_r <= illegal_nx_s;
      error_r   <= error_nx_s;
    end
  end

  assign o_mem_req  = req_r;
  assign o_mem_we   = we_r;
  assign o_addr_sel = asel_r;
  assign o_unit_ien = ien_r;
  assign o_unit_oen = oen_r;
  assign o_busy     = busy_r;
  assign o_halt     = halt_r;
  assign o_illegal  = illegal_r;
  assign o_error    = error_r;

endmodule

// File: tb/tb_bb_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bb_bus_sequencer
// Randomised program stimulus. For every instruction the bench builds the
// expected per-cycle bus activity from the instruction's phase rules (fetch
// for the chosen ack latency, IR load, decode, memory phase, execute move)
// and replays it cycle by cycle, driving ack/start/zero and comparing all
// outputs half a cycle after each rising edge.
// -----------------------------------------------------------------------------
module tb_bb_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_zero, i_mem_ack;
  logic [7:0]  i_instruction;
  logic        o_mem_req, o_mem_we, o_addr_sel, o_busy, o_halt, o_illegal, o_error;
  logic [15:0] o_unit_ien, o_unit_oen;

  bb_bus_sequencer #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_instruction(i_instruction),
    .i_zero(i_zero), .i_mem_ack(i_mem_ack), .o_mem_req(o_mem_req),
    .o_mem_we(o_mem_we), .o_addr_sel(o_addr_sel), .o_unit_ien(o_unit_ien),
    .o_unit_oen(o_unit_oen), .o_busy(o_busy), .o_halt(o_halt),
    .o_illegal(o_illegal), .o_error(o_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req, we, asel;
    logic [15:0] ien, oen;
    logic        busy, halt, ill, err;
  } obs_t;

  typedef struct {
    obs_t       o;
    logic       ack, start, ld_ir, zero;
    logic [7:0] ir;
  } cyc_t;

  cyc_t plan[$];
  int   err_cnt = 0;
  int   chk_cnt = 0;
  int   skin_inc_exp = 0;
  int   skin_inc_got = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.req = o_mem_req; o.we = o_mem_we; o.asel = o_addr_sel;
    o.ien = o_unit_ien; o.oen = o_unit_oen;
    o.busy = o_busy; o.halt = o_halt; o.ill = o_illegal; o.err = o_error;
    return o;
  endfunction

  function automatic logic [15:0] bitv(input logic [3:0] ix);
    logic [15:0] one = 16'h0001;
    return one << ix;
  endfunction

  task automatic push(input obs_t o, input logic ack, input logic start,
                      input logic ld, input logic zero, input logic [7:0] ir);
    cyc_t c;
    c.o = o; c.ack = ack; c.start = start; c.ld_ir = ld; c.zero = zero; c.ir = ir;
    plan.push_back(c);
  endtask

  // Expected cycles for one instruction, starting with its first fetch cycle
  task automatic plan_instr(input logic [7:0] ir, input logic zv, input int lf, input int lm);
    obs_t       o;
    logic [3:0] op = ir[7:4];
    logic [3:0] ix = ir[3:0];
    logic       ok = (ix >= 4'd3) && (ix <= 4'd6);
    int         nh;
    for (int i = 1; i <= lf; i++) begin
      o = '0; o.req = 1'b1; o.busy = 1'b1;
      push(o, i == lf, 1'b0, 1'b0, zv, ir);
    end
    o = '0; o.oen = 16'h1000; o.ien = 16'h0002; o.busy = 1'b1;
    push(o, 1'b0, 1'b0, 1'b1, zv, ir);
    o = '0; o.busy = 1'b1;
    push(o, 1'b0, 1'b0, 1'b0, zv, ir);
    if ((op == 4'h1 || op == 4'h2 || op == 4'h3) && ok) begin
      for (int i = 1; i <= lm; i++) begin
        o = '0; o.req = 1'b1; o.busy = 1'b1;
        o.we   = (op == 4'h2);
        o.asel = (op != 4'h3);
        o.oen  = (op == 4'h2) ? bitv(ix) : 16'h0000;
        push(o, i == lm, 1'b0, 1'b0, zv, ir);
      end
      o = '0; o.busy = 1'b1;
      if (op == 4'h1) begin
        o.oen = 16'h2000; o.ien = bitv(ix);
      end else if (op == 4'h3) begin
        o.oen = 16'h1000; o.ien = bitv(ix);
      end
      push(o, 1'b0, 1'b0, 1'b0, zv, ir);
    end else if (op == 4'hF) begin
      nh = $urandom_range(0, 2);
      for (int i = 0; i <= nh; i++) begin
        o = '0; o.halt = 1'b1;
        push(o, 1'b0, i == nh, 1'b0, zv, ir);
      end
    end else begin
      o = '0; o.busy = 1'b1;
      case (op)
        4'h0: o.busy = 1'b1;
        4'h4: begin o.oen = 16'h0010; o.ien = 16'h0010; end
        4'h5: begin o.oen = 16'h0040; o.ien = 16'h0004; end
        4'h6: if (zv) begin o.oen = 16'h0040; o.ien = 16'h0004; end
        default: o.ill = 1'b1;
      endcase
      push(o, 1'b0, 1'b0, 1'b0, zv, ir);
    end
  endtask

  // Replay the plan: compare at negedge, then drive this cycle's inputs
  task automatic run_plan();
    cyc_t c;
    obs_t got;
    logic prev_ld = 1'b0;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      @(negedge clk);
      if (prev_ld) i_instruction = c.ir;
      got = observe();
      check_val("outputs", 64'(got), 64'(c.o));
      check_val("oen_onehot0", 64'($countones(got.oen) <= 1), 64'd1);
      check_val("ien_onehot0", 64'($countones(got.ien) <= 1), 64'd1);
      if (got.oen[12]) skin_inc_got++;
      if (c.o.oen[12]) skin_inc_exp++;
      // spurious acks without a request and starts while busy must be ignored
      i_mem_ack = c.ack | (!c.o.req && ($urandom_range(0, 3) == 0));
      i_start   = c.start | (c.o.busy && ($urandom_range(0, 3) == 0));
      i_zero    = c.zero;
      prev_ld   = c.ld_ir;
    end
  endtask

  task automatic push_idle(input logic start);
    push('0, 1'b0, start, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    obs_t       o;
    logic [3:0] op, ix;
    i_start = 1'b0; i_zero = 1'b0; i_mem_ack = 1'b0; i_instruction = 8'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_val("reset_state", 64'(observe()), 64'd0);
    rst = 1'b0;

    // Reset in the middle of a fetch
    push_idle(1'b1);
    for (int i = 0; i < 2; i++) begin
      o = '0; o.req = 1'b1; o.busy = 1'b1;
      push(o, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    run_plan();
    #2;
    rst = 1'b1; i_start = 1'b0; i_mem_ack = 1'b1;
    #1;
    check_val("rst_midfetch", 64'(observe()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) push_idle(1'b0);
    run_plan();

    // Directed program
    push_idle(1'b1);
    plan_instr(8'h34, 1'b0, 2, 2);   // LDI DR0, immediate
    plan_instr(8'h25, 1'b0, 1, 3);   // ST DR1
    plan_instr(8'h60, 1'b0, 1, 1);   // BZ not taken
    plan_instr(8'h60, 1'b1, 2, 1);   // BZ taken
    plan_instr(8'h90, 1'b0, 1, 1);   // undefined opcode
    plan_instr(8'h11, 1'b0, 1, 1);   // LD with bad index
    plan_instr(8'h13, 1'b0, 3, 4);   // LD AR
    plan_instr(8'hF0, 1'b0, 1, 1);   // HALT then restart
    plan_instr(8'h40, 1'b0, 1, 1);   // INC
    plan_instr(8'h50, 1'b0, 4, 1);   // BR
    plan_instr(8'h00, 1'b0, 1, 1);   // NOP
    run_plan();

    // Random program
    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(1, 3));
      ix = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(3, 6));
      plan_instr({op, ix}, 1'($urandom_range(0, 1)), $urandom_range(1, 4), $urandom_range(1, 4));
      if (plan.size() > 64) run_plan();
    end
    run_plan();
    check_val("skin_inc_count", 64'(skin_inc_got), 64'(skin_inc_exp));

`ifdef BB_SEQ_TIMEOUT_EN
    // Watchdog: ack never returns, limit 4
    @(negedge clk);
    rst = 1'b1; i_start = 1'b0; i_mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    push_idle(1'b1);
    for (int i = 0; i < 4; i++) begin
      o = '0; o.req = 1'b1; o.busy = 1'b1;
      push(o, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    for (int i = 0; i < 3; i++) begin
      o = '0; o.halt = 1'b1; o.err = 1'b1;
      push(o, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    end
    o = '0; o.halt = 1'b1; o.err = 1'b1;
    push(o, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    run_plan();
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
